// File: rtl/fewcore_pkg.sv
// fewcore_pkg
//   Shared widths and types for the fewcore front end.
//   XLEN     : architectural address width
//   INST_W   : instruction word width
//   PC_STEP  : byte distance between sequential instruction words
//   pf_entry_t : one prefetch queue entry, {pc, inst}
//   pc_align : clears the byte-offset bits of an address
package fewcore_pkg;

  localparam int XLEN   = 32;
  localparam int INST_W = 32;

  localparam logic [XLEN-1:0] PC_STEP = 32'd4;

  typedef struct packed {
    logic [XLEN-1:0]   pc;
    logic [INST_W-1:0] inst;
  } pf_entry_t;

  function automatic logic [XLEN-1:0] pc_align(input logic [XLEN-1:0] pc);
    return {pc[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/prefetch_fifo.sv
// prefetch_fifo
//   In-order circular buffer holding prefetched {pc, inst} entries.
//   Ports:
//     clk      : clock
//     reset    : synchronous active-high reset
//     push_i   : write wdata_i at the tail
//     pop_i    : advance the head
//     clear_i  : drop all entries (takes priority over push/pop)
//     wdata_i  : entry to write
//     rdata_o  : entry at the head (meaningful only when count_o != 0)
//     count_o  : current occupancy, 0..DEPTH
//   Push and pop in the same cycle are allowed when full; a push into an
//   empty queue is not visible at the head until the following cycle.
module prefetch_fifo
  import fewcore_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            push_i,
  input  logic            pop_i,
  input  logic            clear_i,
  input  pf_entry_t       wdata_i,
  output pf_entry_t       rdata_o,
  output logic [CW-1:0]   count_o
);

  pf_entry_t       mem_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;

  // DEPTH is a power of two, so the pointers wrap by natural overflow.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_i) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop_i)  rd_ptr_d = rd_ptr_q + PW'(1);
      unique case ({push_i, pop_i})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: entries are only observed once counted in.
  always_ff @(posedge clk) begin
    if (push_i && !clear_i && !reset) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

  a_no_overflow : assert property (@(posedge clk) disable iff (reset || clear_i)
    (push_i && !pop_i) |-> (count_q != CW'(DEPTH)));

  a_no_underflow : assert property (@(posedge clk) disable iff (reset || clear_i)
    pop_i |-> (count_q != '0));

endmodule

// File: rtl/inst_prefetch.sv
// inst_prefetch
//   Prefetch stage ahead of fetch. Issues sequential word requests to
//   instruction memory, queues returned words with their PCs, and hands
//   them to fetch over a valid/ready handshake. A redirect from execute
//   flushes the queue, marks in-flight responses for discard and restarts
//   at the target.
//   Ports:
//     clk, reset      : clock, synchronous active-high reset
//     redirect        : taken branch/jump this cycle
//     redirect_pc     : branch target (bits [1:0] ignored)
//     imem_req_valid  : request to instruction memory
//     imem_req_ready  : memory accepts the request
//     imem_addr       : word-aligned request address
//     imem_rsp_valid  : in-order response valid
//     imem_rsp_data   : returned instruction word
//     inst_valid      : queue head valid
//     inst_data       : head instruction
//     inst_pc         : head PC
//     inst_ready      : fetch consumes the head
module inst_prefetch
  import fewcore_pkg::*;
#(
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              redirect,
  input  logic [XLEN-1:0]   redirect_pc,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [XLEN-1:0]   imem_addr,
  input  logic              imem_rsp_valid,
  input  logic [INST_W-1:0] imem_rsp_data,
  output logic              inst_valid,
  output logic [INST_W-1:0] inst_data,
  output logic [XLEN-1:0]   inst_pc,
  input  logic              inst_ready
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);

  logic [XLEN-1:0] req_pc_q, req_pc_d;
  logic [XLEN-1:0] rsp_pc_q, rsp_pc_d;
  logic [CW-1:0]   outst_q, outst_d;
  logic [CW-1:0]   discard_q, discard_d;
  logic [CW-1:0]   fifo_count;
  logic [CW:0]     credit_used;

  logic            req_fire;
  logic            rsp_push;
  logic            head_pop;
  pf_entry_t       push_entry;
  pf_entry_t       head_entry;

  // Every queue slot is reserved at request time, so a response can
  // always be written without backpressure.
  assign credit_used    = {1'b0, fifo_count} + {1'b0, outst_q};
  assign imem_req_valid = !reset && !redirect && (credit_used < DEPTH_C);
  assign imem_addr      = req_pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;

  // Responses in the redirect cycle, or while older wrong-path requests
  // are still draining, never reach the queue.
  assign rsp_push   = imem_rsp_valid && !redirect && (discard_q == '0);
  assign head_pop   = inst_valid && inst_ready && !redirect;
  assign push_entry = '{pc: rsp_pc_q, inst: imem_rsp_data};

  always_comb begin
    req_pc_d  = req_pc_q;
    rsp_pc_d  = rsp_pc_q;
    outst_d   = outst_q;
    discard_d = discard_q;
    if (redirect) begin
      req_pc_d  = pc_align(redirect_pc);
      rsp_pc_d  = pc_align(redirect_pc);
      outst_d   = outst_q - CW'(imem_rsp_valid);
      // Everything still in flight after this cycle is wrong-path.
      discard_d = outst_q - CW'(imem_rsp_valid);
    end else begin
      if (req_fire) req_pc_d = req_pc_q + PC_STEP;
      if (rsp_push) rsp_pc_d = rsp_pc_q + PC_STEP;
      outst_d = outst_q + CW'(req_fire) - CW'(imem_rsp_valid);
      if (imem_rsp_valid && (discard_q != '0)) begin
        discard_d = discard_q - CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      req_pc_q  <= RESET_PC;
      rsp_pc_q  <= RESET_PC;
      outst_q   <= '0;
      discard_q <= '0;
    end else begin
      req_pc_q  <= req_pc_d;
      rsp_pc_q  <= rsp_pc_d;
      outst_q   <= outst_d;
      discard_q <= discard_d;
    end
  end

  prefetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (rsp_push),
    .pop_i   (head_pop),
    .clear_i (redirect),
    .wdata_i (push_entry),
    .rdata_o (head_entry),
    .count_o (fifo_count)
  );

  // Head fields are forced to zero while reset is held so fetch never
  // sees stale storage contents.
  assign inst_valid = !reset && (fifo_count != '0);
  assign inst_data  = reset ? '0 : head_entry.inst;
  assign inst_pc    = reset ? '0 : head_entry.pc;

  a_credit_bound : assert property (@(posedge clk) disable iff (reset)
    credit_used <= DEPTH_C);

  a_rsp_expected : assert property (@(posedge clk) disable iff (reset)
    imem_rsp_valid |-> (outst_q != '0));

  a_discard_bound : assert property (@(posedge clk) disable iff (reset)
    discard_q <= outst_q);

endmodule

// File: tb/tb_inst_prefetch.sv
module tb_inst_prefetch;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        inst_valid;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic        inst_ready;

  always #5 clk = ~clk;

  inst_prefetch #(
    .DEPTH    (DEPTH),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .redirect       (redirect),
    .redirect_pc    (redirect_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .inst_valid     (inst_valid),
    .inst_data      (inst_data),
    .inst_pc        (inst_pc),
    .inst_ready     (inst_ready)
  );

  int n_checks = 0;
  int n_errors = 0;

  // memory model: in-order, per-request latency
  typedef struct {
    logic [31:0] addr;
    int          due;
    bit          drop;
  } mreq_t;

  mreq_t       mq[$];
  int          cyc      = 0;
  int          last_due = 0;
  int          lat_min  = 1;
  int          lat_max  = 1;

  // reference state
  logic [31:0] m_req_pc;
  logic [31:0] m_exp_pc;
  int          m_count;
  logic [31:0] delivered[$];

  // sampled DUT outputs
  logic        s_rv, s_iv;
  logic [31:0] s_addr, s_pc, s_data;

  typedef struct {
    bit          rst;
    bit          rdy;
    bit          rv;
    logic [31:0] addr;
    bit          iv;
    logic [31:0] pc;
    int          cnt;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [31:0] word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  function automatic void add(input bit rst, input bit rdy, input bit rv, input logic [31:0] addr,
                              input bit iv, input logic [31:0] pc, input int cnt);
    tbl.push_back('{rst, rdy, rv, addr, iv, pc, cnt});
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock cycle: drive at negedge, sample 1ns later, update the model.
  task automatic step(input bit rst, input bit rdy, input bit mrdy, input bit redir,
                      input logic [31:0] rpc);
    bit    rsp;
    mreq_t e;
    int    due;
    @(negedge clk);
    reset          = rst;
    inst_ready     = rdy;
    imem_req_ready = mrdy;
    redirect       = redir;
    redirect_pc    = rpc;
    rsp            = !rst && (mq.size() > 0) && (mq[0].due <= cyc);
    imem_rsp_valid = rsp;
    imem_rsp_data  = rsp ? word(mq[0].addr) : 32'hDEAD_BEEF;
    #1;
    s_rv   = imem_req_valid;
    s_addr = imem_addr;
    s_iv   = inst_valid;
    s_pc   = inst_pc;
    s_data = inst_data;
    if (rst) begin
      chk("rst_req_valid", {31'd0, s_rv}, 32'd0);
      chk("rst_inst_valid", {31'd0, s_iv}, 32'd0);
      chk("rst_inst_pc", s_pc, 32'd0);
      chk("rst_inst_data", s_data, 32'd0);
      mq.delete();
      m_count  = 0;
      m_req_pc = RESET_PC;
      m_exp_pc = RESET_PC;
      last_due = cyc;
    end else begin
      chk("credit", {31'd0, s_rv},
          {31'd0, (!redir && ((m_count + mq.size()) < DEPTH))});
      chk("occupancy", {31'd0, s_iv}, {31'd0, (m_count != 0)});
      if (s_rv) chk("req_addr", s_addr, m_req_pc);
      if (redir) begin
        if (rsp) void'(mq.pop_front());
        foreach (mq[i]) mq[i].drop = 1'b1;
        m_count  = 0;
        m_req_pc = {rpc[31:2], 2'b00};
        m_exp_pc = {rpc[31:2], 2'b00};
      end else begin
        if (s_iv && rdy && m_count > 0) begin
          chk("inst_pc", s_pc, m_exp_pc);
          chk("inst_data", s_data, word(m_exp_pc));
          delivered.push_back(s_pc);
          m_exp_pc = m_exp_pc + 32'd4;
          m_count--;
        end
        if (rsp) begin
          e = mq.pop_front();
          if (!e.drop) m_count++;
        end
        if (s_rv && mrdy) begin
          due = cyc + $urandom_range(lat_max, lat_min);
          if (due <= last_due) due = last_due + 1;
          last_due = due;
          mq.push_back('{m_req_pc, due, 1'b0});
          m_req_pc = m_req_pc + 32'd4;
        end
      end
      chk("credit_bound", {31'd0, ((m_count + mq.size()) <= DEPTH)}, 32'd1);
    end
    cyc++;
  endtask

  initial begin
    reset          = 1'b1;
    redirect       = 1'b0;
    redirect_pc    = '0;
    inst_ready     = 1'b0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;

    // 1-cycle memory, streaming from reset
    add(1, 0, 0, 0, 0, 0, -1);
    add(1, 0, 0, 0, 0, 0, -1);
    add(0, 1, 1, 32'd0,  0, 32'd0,  -1);
    add(0, 1, 1, 32'd4,  0, 32'd0,  -1);
    add(0, 1, 1, 32'd8,  1, 32'd0,  -1);
    add(0, 1, 1, 32'd12, 1, 32'd4,  -1);
    add(0, 1, 1, 32'd16, 1, 32'd8,  -1);
    add(0, 1, 1, 32'd20, 1, 32'd12, -1);
    // fetch stalled for 10 cycles, then drains
    add(1, 0, 0, 0, 0, 0, -1);
    add(0, 0, 1, 32'd0,  0, 32'd0, -1);
    add(0, 0, 1, 32'd4,  0, 32'd0, -1);
    add(0, 0, 1, 32'd8,  1, 32'd0, -1);
    add(0, 0, 1, 32'd12, 1, 32'd0, -1);
    for (int k = 4; k < 9; k++) add(0, 0, 0, 32'd16, 1, 32'd0, -1);
    add(0, 0, 0, 32'd16, 1, 32'd0,  4);
    add(0, 1, 0, 32'd16, 1, 32'd0,  4);
    add(0, 1, 1, 32'd16, 1, 32'd4,  3);
    add(0, 1, 1, 32'd20, 1, 32'd8,  2);
    add(0, 1, 1, 32'd24, 1, 32'd12, 2);
    add(0, 1, 1, 32'd28, 1, 32'd16, 2);

    lat_min = 1;
    lat_max = 1;
    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].rst, tbl[i].rdy, 1'b1, 1'b0, 32'd0);
      if (!tbl[i].rst) begin
        chk($sformatf("tbl%0d_req_valid", i), {31'd0, s_rv}, {31'd0, tbl[i].rv});
        if (tbl[i].rv) chk($sformatf("tbl%0d_addr", i), s_addr, tbl[i].addr);
        chk($sformatf("tbl%0d_inst_valid", i), {31'd0, s_iv}, {31'd0, tbl[i].iv});
        if (tbl[i].iv) chk($sformatf("tbl%0d_inst_pc", i), s_pc, tbl[i].pc);
        if (tbl[i].cnt >= 0)
          chk($sformatf("tbl%0d_fifo_count", i), 32'(dut.u_fifo.count_o), tbl[i].cnt);
      end
    end

    // redirect with three responses in flight, 3-cycle memory
    lat_min = 3;
    lat_max = 3;
    step(1, 1, 1, 0, 0);
    for (int k = 0; k < 3; k++) step(0, 1, 1, 0, 0);
    delivered.delete();
    step(0, 1, 1, 1, 32'h100);
    step(0, 1, 1, 0, 0);
    chk("c_empty_after_redirect", {31'd0, s_iv}, 32'd0);
    chk("c_req_valid_after_redirect", {31'd0, s_rv}, 32'd1);
    chk("c_target_addr", s_addr, 32'h100);
    for (int k = 0; k < 10; k++) step(0, 1, 1, 0, 0);
    chk("c_first_pc", (delivered.size() > 0) ? delivered[0] : 32'hFFFF_FFFF, 32'h100);

    // redirect coinciding with a response and a pop, 1-cycle memory
    lat_min = 1;
    lat_max = 1;
    step(1, 1, 1, 0, 0);
    for (int k = 0; k < 5; k++) step(0, 1, 1, 0, 0);
    delivered.delete();
    step(0, 1, 1, 1, 32'h100);
    chk("d_head_valid_in_redirect", {31'd0, s_iv}, 32'd1);
    chk("d_rsp_in_redirect", {31'd0, imem_rsp_valid}, 32'd1);
    step(0, 1, 1, 0, 0);
    chk("d_empty_after_redirect", {31'd0, s_iv}, 32'd0);
    chk("d_target_addr", s_addr, 32'h100);
    for (int k = 0; k < 6; k++) step(0, 1, 1, 0, 0);
    chk("d_first_pc", (delivered.size() > 0) ? delivered[0] : 32'hFFFF_FFFF, 32'h100);

    // misaligned target near the top of the address space wraps to 0
    delivered.delete();
    step(0, 1, 1, 1, 32'hFFFF_FFF9);
    step(0, 1, 1, 0, 0);
    chk("e_target_addr", s_addr, 32'hFFFF_FFF8);
    for (int k = 0; k < 8; k++) step(0, 1, 1, 0, 0);
    chk("e_count", delivered.size(), 32'd4 + 32'(delivered.size() >= 4 ? delivered.size() - 4 : 0));
    chk("e_pc0", (delivered.size() > 0) ? delivered[0] : 32'h1, 32'hFFFF_FFF8);
    chk("e_pc1", (delivered.size() > 1) ? delivered[1] : 32'h1, 32'hFFFF_FFFC);
    chk("e_pc2", (delivered.size() > 2) ? delivered[2] : 32'h1, 32'h0000_0000);
    chk("e_pc3", (delivered.size() > 3) ? delivered[3] : 32'h1, 32'h0000_0004);

    // random soak against the reference model
    lat_min = 1;
    lat_max = 4;
    step(1, 0, 0, 0, 0);
    for (int k = 0; k < 3000; k++) begin
      step(0, ($urandom_range(3) != 0), ($urandom_range(3) != 0),
           ($urandom_range(31) == 0), $urandom);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
